// File: rtl/kbd_pkg.sv
// Keypad event buffer: register offsets and bit positions
// shared by the FIFO top level and the bench.
package kbd_pkg;

    localparam logic [2:0] KBD_DATA = 3'b000;
    localparam logic [2:0] KBD_STAT = 3'b010;
    localparam logic [2:0] KBD_CTRL = 3'b100;

    localparam int STAT_IE   = 7;
    localparam int STAT_OVF  = 6;
    localparam int STAT_FULL = 5;
    localparam int STAT_NE   = 4;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_OVF_CLR = 2;

endpackage

// File: rtl/kbd_sync_fifo.sv
// Small synchronous FIFO; push/pop arrive already qualified
// by the caller, flush has priority over both.
module kbd_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush)
            mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/kbd_event_fifo.sv
// Keypad event buffer: queues one code per key press and
// exposes data/status/control registers plus an interrupt.
module kbd_event_fifo #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int CODE_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              key_down,
    input  logic [CODE_W-1:0] key_code,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic [2:0]        address,
    input  logic [15:0]       write_data,
    output logic [15:0]       read_data_output,
    output logic              interrupt
);
    import kbd_pkg::*;

    localparam int CW = PTR_W + 1;

    logic              key_down_q;
    logic              rd_q;
    logic              ovf;
    logic              ie;
    logic [CODE_W-1:0] data_q;

    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [CODE_W-1:0] head;

    logic is_data;
    logic is_stat;
    logic is_ctrl;
    logic key_edge;
    logic pop_ok;
    logic push_ok;
    logic flush;
    logic ctrl_wr;
    logic ovf_event;
    logic unused_wdata;

    assign is_data = read_enable & (address == KBD_DATA);
    assign is_stat = read_enable & (address == KBD_STAT);
    assign is_ctrl = read_enable & (address == KBD_CTRL);

    assign key_edge  = key_down & ~key_down_q;
    assign pop_ok    = is_data & ~rd_q & ~empty;
    assign push_ok   = key_edge & (~full | pop_ok);
    assign ovf_event = key_edge & full & ~pop_ok;

    assign ctrl_wr = write_enable & (address == KBD_CTRL);
    assign flush   = ctrl_wr & write_data[CTRL_FLUSH];

    assign unused_wdata = ^write_data[15:3];

    assign count_next = flush ? '0
                      : count + CW'(push_ok) - CW'(pop_ok);

    kbd_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop_ok),
        .flush (flush),
        .data  (key_code),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_down_q <= 1'b0;
            rd_q       <= 1'b0;
            ovf        <= 1'b0;
            ie         <= 1'b1;
            interrupt  <= 1'b0;
            data_q     <= '0;
        end else begin
            key_down_q <= key_down;
            rd_q       <= is_data;
            interrupt  <= ie & (count_next != '0);
            // hold the first-cycle value for the rest of a long read
            if (is_data && !rd_q)
                data_q <= empty ? '0 : head;
            if (ctrl_wr)
                ie <= write_data[CTRL_IE];
            if (ovf_event)
                ovf <= 1'b1;
            else if (ctrl_wr && write_data[CTRL_OVF_CLR])
                ovf <= 1'b0;
        end
    end

    always_comb begin
        read_data_output = 16'h0000;
        unique case (1'b1)
            is_data: begin
                if (rd_q)
                    read_data_output = 16'(data_q);
                else if (!empty)
                    read_data_output = 16'(head);
            end
            is_stat: begin
                read_data_output[STAT_IE]   = ie;
                read_data_output[STAT_OVF]  = ovf;
                read_data_output[STAT_FULL] = full;
                read_data_output[STAT_NE]   = ~empty;
                read_data_output[3:0]       = 4'(count);
            end
            is_ctrl: read_data_output[0] = ie;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Scenario bench for kbd_event_fifo with a queue scoreboard
// of expected key codes and a model of ie/ovf.
module tb_kbd_event_fifo;
    import kbd_pkg::*;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_down;
    logic [3:0]  key_code;
    logic        read_enable;
    logic        write_enable;
    logic [2:0]  address;
    logic [15:0] write_data;
    logic [15:0] read_data_output;
    logic        interrupt;

    int errors = 0;
    int checks = 0;

    int sb[$];
    bit m_ie;
    bit m_ovf;

    kbd_event_fifo #(
        .DEPTH  (DEPTH),
        .PTR_W  (3),
        .CODE_W (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .key_down         (key_down),
        .key_code         (key_code),
        .read_enable      (read_enable),
        .write_enable     (write_enable),
        .address          (address),
        .write_data       (write_data),
        .read_data_output (read_data_output),
        .interrupt        (interrupt)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        s = 16'h0000;
        s[7] = m_ie;
        s[6] = m_ovf;
        s[5] = (sb.size() == DEPTH);
        s[4] = (sb.size() != 0);
        s[3:0] = 4'(sb.size());
        return s;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic rd_reg(input logic [2:0] a,
                          output logic [15:0] v);
        address = a;
        read_enable = 1'b1;
        #1;
        v = read_data_output;
        read_enable = 1'b0;
        address = KBD_DATA;
        #1;
    endtask

    task automatic press(input logic [3:0] c, input int hold);
        key_code = c;
        key_down = 1'b1;
        if (sb.size() < DEPTH)
            sb.push_back(int'(c));
        else
            m_ovf = 1'b1;
        repeat (hold) cyc();
        key_down = 1'b0;
        cyc();
    endtask

    task automatic wr_ctrl(input logic [15:0] d);
        address = KBD_CTRL;
        write_data = d;
        write_enable = 1'b1;
        cyc();
        write_enable = 1'b0;
        address = KBD_DATA;
        if (d[0])
            sb.delete();
        m_ie = d[1];
        if (d[2])
            m_ovf = 1'b0;
    endtask

    task automatic do_read(input int n, output logic [15:0] v,
                           output bit stable);
        address = KBD_DATA;
        read_enable = 1'b1;
        #1;
        v = read_data_output;
        stable = 1'b1;
        for (int i = 1; i < n; i++) begin
            cyc();
            if (read_data_output !== v)
                stable = 1'b0;
        end
        cyc();
        read_enable = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        key_down = 1'b0;
        key_code = 4'h0;
        read_enable = 1'b0;
        write_enable = 1'b0;
        address = KBD_DATA;
        write_data = 16'h0000;
        sb.delete();
        m_ie = 1'b1;
        m_ovf = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b1;
        key_down = 1'b0;
        key_code = 4'h0;
        read_enable = 1'b0;
        write_enable = 1'b0;
        address = KBD_DATA;
        write_data = 16'h0000;
        cyc();
        cyc();
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", interrupt);
        end
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h0080) begin
            errors++;
            $display("FAIL reset_stat: got %h expected 0080", v);
        end
        rd_reg(KBD_CTRL, v);
        checks++;
        if (v !== 16'h0001) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected 0001", v);
        end
        rd_reg(KBD_DATA, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0000", v);
        end
        rd_reg(3'b110, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL reset_other: got %h expected 0000", v);
        end
        reset = 1'b0;
        sb.delete();
        m_ie = 1'b1;
        m_ovf = 1'b0;
        cyc();
    endtask

    task automatic test_single_press();
        logic [15:0] v;
        int exp;
        do_reset();
        key_code = 4'h5;
        key_down = 1'b1;
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL sp_irq_pre: got %b expected 0", interrupt);
        end
        cyc();
        sb.push_back(5);
        checks++;
        if (interrupt !== 1'b1) begin
            errors++;
            $display("FAIL sp_irq: got %b expected 1", interrupt);
        end
        repeat (19) cyc();
        key_down = 1'b0;
        cyc();
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h0091) begin
            errors++;
            $display("FAIL sp_stat: got %h expected 0091", v);
        end
        exp = sb.pop_front();
        address = KBD_DATA;
        read_enable = 1'b1;
        #1;
        checks++;
        if (read_data_output !== 16'(exp)) begin
            errors++;
            $display("FAIL sp_rd0: got %h expected %h",
                     read_data_output, 16'(exp));
        end
        for (int i = 1; i < 3; i++) begin
            cyc();
            checks++;
            if (read_data_output !== 16'(exp)) begin
                errors++;
                $display("FAIL sp_rd%0d: got %h expected %h", i,
                         read_data_output, 16'(exp));
            end
            if (i == 1) begin
                checks++;
                if (interrupt !== 1'b0) begin
                    errors++;
                    $display("FAIL sp_irq_drop: got %b expected 0",
                             interrupt);
                end
            end
        end
        cyc();
        read_enable = 1'b0;
        cyc();
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== exp_status()) begin
            errors++;
            $display("FAIL sp_stat_end: got %h expected %h",
                     v, exp_status());
        end
    endtask

    task automatic test_full_overflow();
        logic [15:0] v;
        bit st;
        int exp;
        do_reset();
        for (int i = 1; i <= 8; i++)
            press(4'(i), 2);
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h00B8) begin
            errors++;
            $display("FAIL fo_full: got %h expected 00b8", v);
        end
        press(4'hA, 2);
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h00F8) begin
            errors++;
            $display("FAIL fo_ovf: got %h expected 00f8", v);
        end
        checks++;
        if (interrupt !== 1'b1) begin
            errors++;
            $display("FAIL fo_irq: got %b expected 1", interrupt);
        end
        for (int i = 0; i < 8; i++) begin
            exp = sb.pop_front();
            do_read(1, v, st);
            checks++;
            if (v !== 16'(exp)) begin
                errors++;
                $display("FAIL fo_rd%0d: got %h expected %h",
                         i, v, 16'(exp));
            end
        end
        do_read(1, v, st);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL fo_rd_empty: got %h expected 0000", v);
        end
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== exp_status()) begin
            errors++;
            $display("FAIL fo_stat_end: got %h expected %h",
                     v, exp_status());
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] v;
        bit st;
        int exp;
        do_reset();
        for (int i = 1; i <= 8; i++)
            press(4'(i), 1);
        exp = sb.pop_front();
        sb.push_back(12);
        key_code = 4'hC;
        key_down = 1'b1;
        address = KBD_DATA;
        read_enable = 1'b1;
        #1;
        checks++;
        if (read_data_output !== 16'(exp)) begin
            errors++;
            $display("FAIL fp_rd: got %h expected %h",
                     read_data_output, 16'(exp));
        end
        cyc();
        key_down = 1'b0;
        read_enable = 1'b0;
        cyc();
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h00B8) begin
            errors++;
            $display("FAIL fp_stat: got %h expected 00b8", v);
        end
        for (int i = 0; i < 8; i++) begin
            exp = sb.pop_front();
            do_read(1, v, st);
            checks++;
            if (v !== 16'(exp)) begin
                errors++;
                $display("FAIL fp_drain%0d: got %h expected %h",
                         i, v, 16'(exp));
            end
        end
    endtask

    task automatic test_empty_push_read();
        logic [15:0] v;
        bit st;
        int exp;
        do_reset();
        key_code = 4'h9;
        key_down = 1'b1;
        address = KBD_DATA;
        read_enable = 1'b1;
        #1;
        checks++;
        if (read_data_output !== 16'h0000) begin
            errors++;
            $display("FAIL ep_rd: got %h expected 0000",
                     read_data_output);
        end
        cyc();
        sb.push_back(9);
        key_down = 1'b0;
        read_enable = 1'b0;
        cyc();
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h0091) begin
            errors++;
            $display("FAIL ep_stat: got %h expected 0091", v);
        end
        exp = sb.pop_front();
        do_read(3, v, st);
        checks++;
        if (v !== 16'(exp) || !st) begin
            errors++;
            $display("FAIL ep_rd2: got %h stable %0d expected %h",
                     v, st, 16'(exp));
        end
    endtask

    task automatic test_control();
        logic [15:0] v;
        do_reset();
        for (int i = 0; i < 3; i++)
            press(4'(i + 3), 1);
        checks++;
        if (interrupt !== 1'b1) begin
            errors++;
            $display("FAIL ct_irq_on: got %b expected 1", interrupt);
        end
        wr_ctrl(16'h0001);
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL ct_irq_flush: got %b expected 0", interrupt);
        end
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL ct_flush: got %h expected 0000", v);
        end
        wr_ctrl(16'h0002);
        for (int i = 0; i < 9; i++)
            press(4'(i), 1);
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h00F8) begin
            errors++;
            $display("FAIL ct_ovf_set: got %h expected 00f8", v);
        end
        key_code = 4'hD;
        key_down = 1'b1;
        m_ovf = 1'b1;
        wr_ctrl(16'h0006);
        key_down = 1'b0;
        cyc();
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h00F8) begin
            errors++;
            $display("FAIL ct_ovf_wins: got %h expected 00f8", v);
        end
        wr_ctrl(16'h0006);
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== exp_status()) begin
            errors++;
            $display("FAIL ct_ovf_clr: got %h expected %h",
                     v, exp_status());
        end
        address = KBD_DATA;
        write_data = 16'hFFFF;
        write_enable = 1'b1;
        cyc();
        write_enable = 1'b0;
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h00B8) begin
            errors++;
            $display("FAIL ct_other_wr: got %h expected 00b8", v);
        end
        wr_ctrl(16'h0000);
        cyc();
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL ct_ie_off: got %b expected 0", interrupt);
        end
        rd_reg(KBD_CTRL, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL ct_ctrl_rd: got %h expected 0000", v);
        end
        wr_ctrl(16'h0001);
        press(4'h7, 1);
        cyc();
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== exp_status() || interrupt !== 1'b0) begin
            errors++;
            $display("FAIL ct_masked: got %h/%b expected %h/0",
                     v, interrupt, exp_status());
        end
    endtask

    task automatic test_wrap();
        logic [15:0] v;
        bit st;
        int exp;
        do_reset();
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 6; i++)
                press(4'((r * 6 + i) % 16), 1);
            for (int i = 0; i < 6; i++) begin
                exp = sb.pop_front();
                do_read(1, v, st);
                checks++;
                if (v !== 16'(exp)) begin
                    errors++;
                    $display("FAIL wr_r%0d_%0d: got %h expected %h",
                             r, i, v, 16'(exp));
                end
            end
        end
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h0080) begin
            errors++;
            $display("FAIL wr_stat: got %h expected 0080", v);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] v;
        do_reset();
        for (int i = 0; i < 4; i++)
            press(4'(i + 1), 1);
        rd_reg(KBD_STAT, v);
        checks++;
        if (v !== 16'h0094) begin
            errors++;
            $display("FAIL ar_pre: got %h expected 0094", v);
        end
        #2;
        address = KBD_STAT;
        read_enable = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if (read_data_output !== 16'h0080 || interrupt !== 1'b0) begin
            errors++;
            $display("FAIL ar_now: got %h/%b expected 0080/0",
                     read_data_output, interrupt);
        end
        read_enable = 1'b0;
        address = KBD_DATA;
        cyc();
        reset = 1'b0;
        sb.delete();
        m_ie = 1'b1;
        m_ovf = 1'b0;
        cyc();
        rd_reg(KBD_DATA, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL ar_data: got %h expected 0000", v);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_full_overflow();
        test_full_push_pop();
        test_empty_push_read();
        test_control();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
